// File: rtl/flag_register_unit.sv
// Condition-flag producer: N/Z/C/V registers plus in-flight flag-write tracker.
// Optional FLAG_BYPASS_EN: forward committing flags combinationally.
module flag_register_unit #(
  parameter int WIDTH           = 32,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_issue,
  output logic             issue_ready,
  input  logic             flag_write,
  input  logic             cond_ex,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] result,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             carry_in,
  input  logic             flush,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             flags_valid
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FULL
  } trk_t;

  trk_t          st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          n_q, z_q, c_q, v_q;
  logic          n_nx, z_nx, c_nx, v_nx;
  logic          commit, acc;
  logic          op_add, op_sub;
  logic          res_msb;

  assign res_msb = result[WIDTH-1];
  assign op_add  = (alu_op == 2'b00);
  assign op_sub  = (alu_op == 2'b01);
  assign commit  = flag_write & cond_ex & (alu_op != 2'b11);
  assign acc     = flag_issue & issue_ready;

  // Next flag values; logic ops leave C/V alone
  always_comb begin
    n_nx = n_q;
    z_nx = z_q;
    c_nx = c_q;
    v_nx = v_q;
    if (commit) begin
      n_nx = res_msb;
      z_nx = ~|result;
      unique case (1'b1)
        op_add: begin
          c_nx = carry_in;
          v_nx = (a_msb == b_msb) & (res_msb != a_msb);
        end
        op_sub: begin
          c_nx = carry_in;
          v_nx = (a_msb != b_msb) & (res_msb != a_msb);
        end
        default: ;
      endcase
    end
  end

  // Outstanding count; flush wins, no underflow
  always_comb begin
    cnt_nx = cnt;
    if (flush)
      cnt_nx = '0;
    else if (acc & ~flag_write)
      cnt_nx = cnt + CONE;
    else if (~acc & flag_write & (cnt != '0))
      cnt_nx = cnt - CONE;
  end

  // Tracker state follows the next count
  always_comb begin
    if (cnt_nx == '0)
      st_nx = IDLE;
    else if (cnt_nx == CMAX)
      st_nx = FULL;
    else
      st_nx = BUSY;
  end

  // Architectural flags and tracker registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      cnt <= '0;
      st  <= IDLE;
    end else begin
      n_q <= n_nx;
      z_q <= z_nx;
      c_q <= c_nx;
      v_q <= v_nx;
      cnt <= cnt_nx;
      st  <= st_nx;
    end
  end

  assign issue_ready = (st != FULL);

`ifdef FLAG_BYPASS_EN
  assign N = n_nx;
  assign Z = z_nx;
  assign C = c_nx;
  assign V = v_nx;
  assign flags_valid = (st == IDLE) |
                       ((cnt == CONE) & flag_write);
`else
  assign N = n_q;
  assign Z = z_q;
  assign C = c_q;
  assign V = v_q;
  assign flags_valid = (st == IDLE);
`endif

endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed plan steps then random traffic
// checked against an operand-level arithmetic model.
module tb_flag_register_unit;

  localparam int MAXO = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_issue = 1'b0;
  logic        issue_ready;
  logic        flag_write = 1'b0;
  logic        cond_ex = 1'b0;
  logic [1:0]  alu_op = 2'b11;
  logic [31:0] result = '0;
  logic        a_msb = 1'b0;
  logic        b_msb = 1'b0;
  logic        carry_in = 1'b0;
  logic        flush = 1'b0;
  logic        N, Z, C, V;
  logic        flags_valid;

  flag_register_unit #(
    .WIDTH(32),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flag_issue(flag_issue),
    .issue_ready(issue_ready),
    .flag_write(flag_write),
    .cond_ex(cond_ex),
    .alu_op(alu_op),
    .result(result),
    .a_msb(a_msb),
    .b_msb(b_msb),
    .carry_in(carry_in),
    .flush(flush),
    .N(N),
    .Z(Z),
    .C(C),
    .V(V),
    .flags_valid(flags_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int   m_cnt = 0;
  logic m_n = 0, m_z = 0, m_c = 0, m_v = 0;
  logic p_n, p_z, p_c, p_v;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".N"}, N, m_n);
    chk({tag, ".Z"}, Z, m_z);
    chk({tag, ".C"}, C, m_c);
    chk({tag, ".V"}, V, m_v);
    chk({tag, ".ready"}, issue_ready, m_cnt < MAXO);
    chk({tag, ".valid"}, flags_valid, m_cnt == 0);
  endtask

  // Drive ALU pins from real operands; expected flags from arithmetic
  task automatic alu(input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    longint      ls;
    r = '0;
    p_c = 1'b0;
    p_v = 1'b0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        p_c = s[32];
        ls = longint'($signed(a)) + longint'($signed(b));
        p_v = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      end
      2'b01: begin
        r = a - b;
        p_c = (a >= b);
        ls = longint'($signed(a)) - longint'($signed(b));
        p_v = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      end
      2'b10: r = a & b;
      default: r = $urandom;
    endcase
    p_n = r[31];
    p_z = (r == 0);
    alu_op = op;
    result = r;
    a_msb = a[31];
    b_msb = b[31];
    carry_in = p_c;
  endtask

  task automatic idle();
    flag_issue = 1'b0;
    flag_write = 1'b0;
    cond_ex = 1'b0;
    flush = 1'b0;
  endtask

  // One clock: model update at the edge, then check with idle inputs
  task automatic step(input string tag);
    bit acc;
    @(posedge clk);
    if (flag_write && cond_ex && alu_op != 2'b11) begin
      m_n = p_n;
      m_z = p_z;
      if (alu_op != 2'b10) begin
        m_c = p_c;
        m_v = p_v;
      end
    end
    acc = flag_issue && (m_cnt < MAXO);
    if (flush) m_cnt = 0;
    else if (acc && !flag_write) m_cnt++;
    else if (!acc && flag_write && m_cnt > 0) m_cnt--;
    #1;
    idle();
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_n = 0;
    m_z = 0;
    m_c = 0;
    m_v = 0;
  endtask

  initial begin
    // reset asserted from time 0, checked before any edge
    #2;
    chk_all("reset0");
    #10;
    rst_n = 1'b1;

    // issue, wait, then sub 0-0
    flag_issue = 1'b1;
    step("issue1");
    chk("issue1.fv_low", flags_valid, 1'b0);
    step("wait1");
    chk("wait1.fv_low", flags_valid, 1'b0);
    flag_write = 1'b1;
    cond_ex = 1'b1;
    alu(2'b01, 32'd0, 32'd0);
    step("sub0");
    chk("sub0.Zc", Z, 1'b1);
    chk("sub0.Cc", C, 1'b1);

    // add overflow, then logic zero holds C/V
    flag_write = 1'b1;
    cond_ex = 1'b1;
    alu(2'b00, 32'h7fff_ffff, 32'd1);
    step("addovf");
    chk("addovf.Nc", N, 1'b1);
    chk("addovf.Vc", V, 1'b1);
    flag_write = 1'b1;
    cond_ex = 1'b1;
    alu(2'b10, 32'd0, 32'd0);
    step("logic0");
    chk("logic0.Vc", V, 1'b1);

    // fill tracker
    for (int i = 0; i < 3; i++) begin
      flag_issue = 1'b1;
      step("fill");
    end
    chk("full.ready", issue_ready, 1'b0);
    flag_issue = 1'b1;
    step("issue4");
    flag_issue = 1'b1;
    flag_write = 1'b1;
    cond_ex = 1'b1;
    alu(2'b00, 32'd10, 32'd20);
    step("iw_full");
    chk("iw_full.ready", issue_ready, 1'b1);

    // count 2: flush with write
    flush = 1'b1;
    flag_write = 1'b1;
    cond_ex = 1'b1;
    alu(2'b00, 32'd2, 32'd3);
    step("flushw");
    chk("flushw.fv", flags_valid, 1'b1);

    // cond fail retire, then underflow attempt
    flag_issue = 1'b1;
    step("issue_c");
    flag_write = 1'b1;
    cond_ex = 1'b0;
    alu(2'b01, 32'd5, 32'd5);
    step("condfail");
    flag_write = 1'b1;
    cond_ex = 1'b0;
    alu(2'b01, 32'd5, 32'd5);
    step("underflow");
    flag_issue = 1'b1;
    step("after_uf");
    flag_write = 1'b1;
    cond_ex = 1'b1;
    alu(2'b11, 32'd1, 32'd1);
    step("noeffect");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      flag_issue = ($urandom_range(0, 1) == 1);
      flag_write = ($urandom_range(0, 9) < 4);
      cond_ex = ($urandom_range(0, 9) < 8);
      flush = ($urandom_range(0, 19) == 0);
      alu(2'($urandom_range(0, 3)), a, b);
      step("rand");
    end

    // build state then reset mid-cycle
    flag_issue = 1'b1;
    flag_write = 1'b1;
    cond_ex = 1'b1;
    alu(2'b01, 32'd0, 32'd1);
    step("pre_rst");
    flag_issue = 1'b1;
    step("pre_rst2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("rst_mid");
    #3;
    rst_n = 1'b1;
    step("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
